// File: rtl/uart_tx_app_pkg.sv
// Purpose: shared constants, transmitter state encoding and button-to-character mapping for uart_tx_app.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Ports: none. Holds CHAR_BTN0..CHAR_BTN3, DATA_BITS, FRAME_BITS, tx_state_t and btn_to_char().
package uart_tx_app_pkg;

    localparam logic [7:0] CHAR_BTN0 = 8'h41; // 'A'
    localparam logic [7:0] CHAR_BTN1 = 8'h42; // 'B'
    localparam logic [7:0] CHAR_BTN2 = 8'h43; // 'C'
    localparam logic [7:0] CHAR_BTN3 = 8'h44; // 'D'

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10; // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Lowest set button index wins; callers only use the result when btn != 0.
    function automatic logic [7:0] btn_to_char(input logic [3:0] btn);
        if (btn[0])      return CHAR_BTN0;
        else if (btn[1]) return CHAR_BTN1;
        else if (btn[2]) return CHAR_BTN2;
        else if (btn[3]) return CHAR_BTN3;
        else             return 8'h00;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Purpose: 8N1 UART serializer (FSM, baud counter, shift register), LSB first.
// Latency: line/active change the cycle after start_vld; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: none; start_vld is ignored unless IDLE, so the caller must gate it on busy.
//
// Ports: clk_i/rst_i (sync, active-high); start_vld + byte_dat launch a frame;
//        line is the serial output (idle high); active is high for the whole frame;
//        done pulses for one cycle during the last STOP cycle.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_vld,
    input  logic [7:0] byte_dat,
    output logic       line,
    output logic       active,
    output logic       done
);
    import uart_tx_app_pkg::*;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST      = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST_DATA  = BIT_W'(DATA_BITS);

    tx_state_t         state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    // Position within the frame: 0 = start, 1..8 = data, 9 = stop.
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic              line_nxt, active_nxt;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start_vld) begin
                    state_nxt = START;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    shreg_nxt = byte_dat;
                end
            end
            START: begin
                if (baud_last) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = bit_cnt + BIT_W'(1);
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = bit_cnt + BIT_W'(1);
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == BIT_LAST_DATA) begin
                        state_nxt = STOP;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    done      = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so the pin never glitches.
        line_nxt = 1'b1;
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shreg_nxt[0];
            default: line_nxt = 1'b1;
        endcase
        active_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            line     <= 1'b1;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            line     <= line_nxt;
            active   <= active_nxt;
        end
    end

endmodule

// File: rtl/uart_tx_app.sv
// Purpose: button-triggered UART TX; a free-running rate timer paces one character frame per accepted tick.
// Latency: line drops to the start bit the cycle after an accepting tick (+2 cycles press-to-sample with sync).
// Backpressure: ticks arriving while a frame is in flight are dropped, never queued.
//
// Ports: clk_i, rst_i (sync, active-high); button_i[3:0] active-high, bit n selects 'A'+n,
//        lowest index wins; uart_tx_data_o serial line (idle high, 8N1, LSB first);
//        uart_tx_active_o high for the full frame.
// Build option: define UART_TX_APP_SYNC_EN to pass button_i through a 2-flop synchronizer.
module uart_tx_app #(
    parameter int DEFAULT_SEND_RATE = 750,
    parameter int CLKS_PER_BIT      = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] button_i,
    output logic       uart_tx_data_o,
    output logic       uart_tx_active_o
);
    import uart_tx_app_pkg::*;

    localparam int RATE_W = (DEFAULT_SEND_RATE > 1) ? $clog2(DEFAULT_SEND_RATE) : 1;
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(DEFAULT_SEND_RATE - 1);

    logic [RATE_W-1:0] rate_cnt;
    logic              rate_tick;
    logic [3:0]        btn_use;
    logic              start_vld;
    logic              tx_busy;
    logic              tx_done;

    // Rate timer runs from reset regardless of buttons; tick is the terminal count.
    assign rate_tick = (rate_cnt == RATE_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rate_cnt <= '0;
        end else if (rate_tick) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= rate_cnt + RATE_W'(1);
        end
    end

`ifdef UART_TX_APP_SYNC_EN
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= button_i;
            btn_sync <= btn_meta;
        end
    end

    assign btn_use = btn_sync;
`else
    assign btn_use = button_i;
`endif

    assign start_vld = rate_tick && !tx_busy && (btn_use != 4'b0000);

    // Busy spans from the accepting tick through the last STOP cycle, so the
    // next frame can only be accepted once the serializer is back in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_busy <= 1'b0;
        end else if (start_vld) begin
            tx_busy <= 1'b1;
        end else if (tx_done) begin
            tx_busy <= 1'b0;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_vld (start_vld),
        .byte_dat  (btn_to_char(btn_use)),
        .line      (uart_tx_data_o),
        .active    (uart_tx_active_o),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_uart_tx_app.sv
// Purpose: self-checking bench for uart_tx_app with a cycle-level frame model and a line decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_app;
    localparam int RATE      = 750;
    localparam int CPB       = 10;
    localparam int FRAME_CYC = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       line;
    logic       active;

    uart_tx_app #(
        .DEFAULT_SEND_RATE(RATE),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .button_i        (btn),
        .uart_tx_data_o  (line),
        .uart_tx_active_o(active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: timer value, position inside the current frame (-1 = idle), frame byte.
    int         m_tcnt = 0;
    int         m_pos  = -1;
    logic [7:0] m_byte = 8'h00;
    logic       exp_line   = 1'b1;
    logic       exp_active = 1'b0;
`ifdef UART_TX_APP_SYNC_EN
    logic [3:0] m_h1 = 4'b0000;
    logic [3:0] m_h2 = 4'b0000;
`endif

    // Line decoder state and results.
    logic       prev_active = 1'b0;
    int         d_len = 0;
    logic [9:0] d_bits = '0;
    logic [7:0] q_byte[$];
    int         q_len[$];
    logic       q_frm[$];
    int         starts[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ASCII 'A' + lowest set index, -1 when no button.
    function automatic int char_for(input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) return 'h41 + i;
        end
        return -1;
    endfunction

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_advance();
        logic [3:0] eff;
        logic       tick;
        int         slot;
`ifdef UART_TX_APP_SYNC_EN
        eff = m_h2;
`else
        eff = btn;
`endif
        if (rst) begin
            m_tcnt = 0;
            m_pos  = -1;
`ifdef UART_TX_APP_SYNC_EN
            m_h1 = 4'b0000;
            m_h2 = 4'b0000;
`endif
        end else begin
            tick   = (m_tcnt == RATE - 1);
            m_tcnt = tick ? 0 : m_tcnt + 1;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME_CYC) m_pos = -1;
            end else if (tick && eff != 4'b0000) begin
                m_pos  = 0;
                m_byte = 8'(char_for(eff));
            end
`ifdef UART_TX_APP_SYNC_EN
            m_h2 = m_h1;
            m_h1 = btn;
`endif
        end
        exp_active = (m_pos >= 0);
        if (m_pos < 0) begin
            exp_line = 1'b1;
        end else begin
            slot = m_pos / CPB;
            if (slot == 0)      exp_line = 1'b0;
            else if (slot == 9) exp_line = 1'b1;
            else                exp_line = m_byte[slot-1];
        end
    endtask

    task automatic decode();
        if (active && !prev_active) begin
            d_len = 0;
            starts.push_back(cyc);
        end
        if (active) begin
            if ((d_len % CPB) == (CPB / 2) && (d_len / CPB) < 10) d_bits[d_len / CPB] = line;
            d_len++;
        end
        if (!active && prev_active) begin
            q_byte.push_back(d_bits[8:1]);
            q_len.push_back(d_len);
            q_frm.push_back(d_bits[0] == 1'b0 && d_bits[9] == 1'b1);
        end
        prev_active = active;
    endtask

    // One clock: model update, then sample the DUT on the falling edge.
    task automatic step();
        model_advance();
        @(negedge clk);
        cyc++;
        check("line", line, exp_line);
        check("active", active, exp_active);
        decode();
    endtask

    task automatic wait_frame(input int budget, input string tag);
        int n0;
        int k;
        n0 = q_byte.size();
        k  = 0;
        while (q_byte.size() == n0 && k < budget) begin
            step();
            k++;
        end
        check({tag, "_timeout"}, 32'(q_byte.size() > n0), 1);
    endtask

    task automatic wait_rise(input int budget, input string tag);
        int n0;
        int k;
        n0 = starts.size();
        k  = 0;
        while (starts.size() == n0 && k < budget) begin
            step();
            k++;
        end
        check({tag, "_timeout"}, 32'(starts.size() > n0), 1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_byte);
        if (q_byte.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            check({tag, "_byte"}, q_byte.pop_front(), exp_byte);
            check({tag, "_len"}, q_len.pop_front(), FRAME_CYC);
            check({tag, "_framing"}, q_frm.pop_front(), 1);
        end
    endtask

    task automatic clear_decoded();
        q_byte.delete();
        q_len.delete();
        q_frm.delete();
        starts.delete();
    endtask

    initial begin
        int rel;
        int n_idle;
        int dur;

        // Reset behaviour.
        rst = 1'b1;
        btn = 4'b0000;
        repeat (16) begin
            step();
            check("rst_line", line, 1);
            check("rst_active", active, 0);
        end
        rst = 1'b0;
        repeat (16) begin
            step();
            check("post_rst_line", line, 1);
            check("post_rst_active", active, 0);
        end

        // Single press.
        btn = 4'b0001;
        wait_frame(1000, "single");
        btn = 4'b0000;
        check_frame("single", 8'h41);
        repeat (16) step();

        // Walk buttons.
        for (int i = 1; i < 4; i++) begin
            btn = 4'(1 << i);
            wait_frame(1000, "walk");
            btn = 4'b0000;
            repeat (16) step();
            check_frame("walk", 8'(8'h41 + i));
        end

        // Priority.
        btn = 4'b1010;
        wait_frame(1000, "prio");
        btn = 4'b0000;
        repeat (16) step();
        check_frame("prio", 8'h42);

        // Repeat while held, then idle.
        clear_decoded();
        btn = 4'b0001;
        repeat (3000) step();
        btn = 4'b0000;
        repeat (120) step();
        check("repeat_count", starts.size(), 4);
        for (int i = 1; i < starts.size(); i++) begin
            check("repeat_spacing", starts[i] - starts[i-1], RATE);
        end
        while (q_byte.size() > 0) check_frame("repeat", 8'h41);
        n_idle = starts.size();
        repeat (3500) step();
        check("idle_no_start", starts.size(), n_idle);

        // Release during DATA.
        clear_decoded();
        btn = 4'b0100;
        wait_rise(1000, "rel_rise");
        repeat (30) step();
        btn = 4'b0000;
        wait_frame(200, "rel");
        check_frame("rel", 8'h43);
        repeat (16) step();

        // Reset during DATA, then the timer must restart from zero.
        btn = 4'b1000;
        wait_rise(1000, "mrst_rise");
        repeat (40) step();
        rst = 1'b1;
        step();
        check("mrst_line", line, 1);
        check("mrst_active", active, 0);
        rel = cyc;
        rst = 1'b0;
        btn = 4'b0001;
        clear_decoded();
        wait_frame(1000, "mrst_next");
        btn = 4'b0000;
        if (starts.size() > 0) check("mrst_restart", starts[0] - rel, RATE);
        check_frame("mrst_next", 8'h41);
        repeat (16) step();

        // Random buttons with occasional resets, checked cycle by cycle against the model.
        for (int s = 0; s < 24; s++) begin
            btn = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 400);
            repeat (dur) step();
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end
        end
        btn = 4'b0000;
        repeat (200) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
